wb_regfile_stage: RTL and testbench
===================================

Name: wb_regfile_stage

Overview:
Writeback stage of the dual-issue pipeline. It consumes the registered Execute/WB slot bundle and selects each slot's result (AU, MUL or LSU). It commits up to two results per cycle into the 32x32 architectural register file, which has 4 read ports and 2 write ports. It also provides write-through bypass to decode, WB forwarding data to execute, and a 64-bit retired-instruction counter.

Parameters:
XLEN, 32, data width of results and registers
NREGS, 32, architectural register count (x0 hardwired zero)
CNT_W, 64, retired-instruction counter width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous reset, active-low
reg_write1_wb  in  1  slot1 write enable
reg_write2_wb  in  1  slot2 write enable (slot2 is the younger instruction)
rd1_wb  in  5  slot1 destination
rd2_wb  in  5  slot2 destination
au_mul_lsu1_wb  in  3  slot1 result select, one-hot
au_mul_lsu2_wb  in  3  slot2 result select, one-hot
au1_wb, au2_wb  in  XLEN  AU results per slot
mul1_wb, mul2_wb  in  XLEN  MUL results per slot
lsu_wb  in  XLEN  shared LSU result
rs1a, rs2a, rs1b, rs2b  in  5 each  decode read addresses (a = slot1, b = slot2)
rd_data1a, rd_data2a, rd_data1b, rd_data2b  out  XLEN each  read data
wb_en1, wb_en2  out  1 each  effective commit enable per slot (forwarding qualifiers)
wb_data1, wb_data2  out  XLEN each  selected result per slot
retired_count  out  CNT_W  retired instruction count
sel_err  out  1  registered pulse on an illegal select

Behaviour:
- Reset (async, rst_n=0): all registers x1..x31 = 0, retired_count = 0, sel_err = 0. Read outputs are therefore 0 during and after reset until the first write.
- Select decode:
  - 3'b001 = AU, 3'b010 = MUL, 3'b100 = LSU, 3'b000 = bubble.
  - Any other code is illegal: that slot gets no write and is not counted.
- wb_dataN is combinational: the mux of the slot's selected result, 0 for bubble or illegal.
- wb_enN = reg_writeN_wb & legal non-bubble select & (rdN != 0).
- LSU conflict: both slots select LSU -> slot1 proceeds, slot2 is suppressed (no write, not counted) and treated as illegal.
- sel_err is registered. It is 1 on the cycle after any illegal condition, otherwise 0.
- Commit: register writes occur on the posedge of the cycle in which wb_enN=1, giving single-cycle commit latency.
- WAW: if wb_en1 & wb_en2 & (rd1 == rd2), only the slot2 value is written.
- x0: writes to x0 are always ignored, and reads of x0 always return 0, bypass included.
- Read ports are combinational with same-cycle write-through bypass, priority highest first:
  1. addr == 0 -> 0
  2. wb_en2 & rd2 == addr -> wb_data2
  3. wb_en1 & rd1 == addr -> wb_data1
  4. otherwise the array contents
- Retire count: retired_count += (slot1 legal non-bubble) + (slot2 legal non-bubble) each cycle. The count includes non-writing instructions (stores, branches) that carry a legal select. It wraps modulo 2^CNT_W.
- No stall input: an upstream flush arrives as an all-zero bundle, which becomes a bubble with no write and no count.
- Reset mid-operation: any in-flight write on that edge is discarded and the array is cleared.

Decomposition:
- Shared package holds:
  - SEL_AU / SEL_MUL / SEL_LSU / SEL_NONE constants (3-bit one-hot)
  - REG_ZERO address constant
  - XLEN default
- Sub-module regfile_4r2w contains:
  - the array
  - the ordered two-write commit (slot2 last)
  - the 4-port bypassed read
- The top level holds the select muxes, enable/error logic and the retire counter.

Test Plan:
- Reset, then read all 4 ports at x5 -> 0. Assert rst_n mid-run after writing x5=0xDEADBEEF -> x5 reads 0 while reset is asserted.
- Slot1 AU to x3 = 0x11, slot2 MUL to x4 = 0x22 -> same cycle rd_data1a(rs=3) = 0x11 via bypass. Next cycle the array holds both values; retired_count = 2.
- Both slots write x7 (AU1 = 0xA, AU2 = 0xB) -> the bypass read and the next-cycle array read of x7 are both 0xB.
- Slot1 writes x0 = 0xFFFF_FFFF with reg_write=1 -> wb_en1 = 0, x0 reads 0, retired_count increments by 1.
- Both slots select LSU (lsu_wb = 0x55, rd1 = 8, rd2 = 9) -> x8 = 0x55, x9 unchanged, sel_err = 1 for exactly one cycle, count +1.
- Preload retired_count to 2^64-1 via forced state; commit 2 legal instructions -> count = 1.

Source files
------------

// File: rtl/wb_regfile_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_regfile_stage_pkg
// Description : Shared constants for the writeback stage and its register file.
//               - result-select codes (3-bit one-hot, zero = bubble)
//               - architectural zero-register address
//               - default data width
//               - helper that classifies a select code as legal
// Revision    : 1.0 - initial release
// ============================================================================
package wb_regfile_stage_pkg;

  localparam int XLEN_DEFAULT = 32;

  localparam logic [2:0] SEL_NONE = 3'b000;
  localparam logic [2:0] SEL_AU   = 3'b001;
  localparam logic [2:0] SEL_MUL  = 3'b010;
  localparam logic [2:0] SEL_LSU  = 3'b100;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // A select is legal when it is a bubble or names exactly one source.
  function automatic logic sel_legal(input logic [2:0] sel);
    logic r;
    case (sel)
      SEL_NONE, SEL_AU, SEL_MUL, SEL_LSU: r = 1'b1;
      default:                            r = 1'b0;
    endcase
    return r;
  endfunction

endpackage : wb_regfile_stage_pkg
`default_nettype wire

// File: rtl/wb_regfile_stage_regfile_4r2w.sv
`default_nettype none
// ============================================================================
// Module      : regfile_4r2w
// Description : Architectural register file, 4 combinational read ports and
//               2 write ports. Entry 0 is never written and always reads 0.
//               Write port 2 carries the younger instruction and is applied
//               last, so it wins a same-address collision. Reads see the
//               writes of the current cycle (write-through bypass).
// Ports       : clk, rst_n          clock, async active-low reset
//               we1/waddr1/wdata1   write port 1 (older slot)
//               we2/waddr2/wdata2   write port 2 (younger slot)
//               raddr[4]/rdata[4]   read ports
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_4r2w
  import wb_regfile_stage_pkg::*;
#(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int NREGS = 32,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            we1,
  input  logic [AW-1:0]   waddr1,
  input  logic [XLEN-1:0] wdata1,
  input  logic            we2,
  input  logic [AW-1:0]   waddr2,
  input  logic [XLEN-1:0] wdata2,
  input  logic [AW-1:0]   raddr [4],
  output logic [XLEN-1:0] rdata [4]
);

  localparam logic [AW-1:0] c_zero = AW'(REG_ZERO);

  logic [XLEN-1:0] r_mem [NREGS];

  // Port 2 is written after port 1 so its value survives a WAW collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (we1 && (waddr1 != c_zero)) begin
        r_mem[waddr1] <= wdata1;
      end
      if (we2 && (waddr2 != c_zero)) begin
        r_mem[waddr2] <= wdata2;
      end
    end
  end

  // Bypass order mirrors commit order: zero, then younger, then older, then array.
  always_comb begin
    for (int p = 0; p < 4; p++) begin
      rdata[p] = r_mem[raddr[p]];
      if (raddr[p] == c_zero) begin
        rdata[p] = '0;
      end else if (we2 && (waddr2 == raddr[p])) begin
        rdata[p] = wdata2;
      end else if (we1 && (waddr1 == raddr[p])) begin
        rdata[p] = wdata1;
      end
    end
  end

endmodule : regfile_4r2w
`default_nettype wire

// File: rtl/wb_regfile_stage.sv
`default_nettype none
// ============================================================================
// Module      : wb_regfile_stage
// Description : Writeback stage of the dual-issue pipeline. Selects each slot's
//               result (AU / MUL / LSU), qualifies the commit enables, writes
//               the 4R2W register file, flags illegal selects one cycle later
//               and counts retired instructions.
// Ports       : clk, rst_n                     clock, async active-low reset
//               reg_write{1,2}_wb, rd{1,2}_wb  slot write enable / destination
//               au_mul_lsu{1,2}_wb             slot result select (one-hot)
//               au{1,2}_wb, mul{1,2}_wb        per-slot AU / MUL results
//               lsu_wb                         shared LSU result
//               rs1a, rs2a, rs1b, rs2b         decode read addresses
//               rd_data1a..rd_data2b           bypassed read data
//               wb_en{1,2}, wb_data{1,2}       forwarding qualifiers / data
//               retired_count                  retired-instruction counter
//               sel_err                        registered illegal-select pulse
// Revision    : 1.0 - initial release
// ============================================================================
module wb_regfile_stage
  import wb_regfile_stage_pkg::*;
#(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int NREGS = 32,
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             reg_write1_wb,
  input  logic             reg_write2_wb,
  input  logic [4:0]       rd1_wb,
  input  logic [4:0]       rd2_wb,
  input  logic [2:0]       au_mul_lsu1_wb,
  input  logic [2:0]       au_mul_lsu2_wb,
  input  logic [XLEN-1:0]  au1_wb,
  input  logic [XLEN-1:0]  au2_wb,
  input  logic [XLEN-1:0]  mul1_wb,
  input  logic [XLEN-1:0]  mul2_wb,
  input  logic [XLEN-1:0]  lsu_wb,
  input  logic [4:0]       rs1a,
  input  logic [4:0]       rs2a,
  input  logic [4:0]       rs1b,
  input  logic [4:0]       rs2b,
  output logic [XLEN-1:0]  rd_data1a,
  output logic [XLEN-1:0]  rd_data2a,
  output logic [XLEN-1:0]  rd_data1b,
  output logic [XLEN-1:0]  rd_data2b,
  output logic             wb_en1,
  output logic             wb_en2,
  output logic [XLEN-1:0]  wb_data1,
  output logic [XLEN-1:0]  wb_data2,
  output logic [CNT_W-1:0] retired_count,
  output logic             sel_err
);

  // --------------------------------------------------------------------------
  // Select classification
  // --------------------------------------------------------------------------
  logic w_lsu_conflict;
  logic w_illegal1;
  logic w_illegal2;
  logic w_active1;
  logic w_active2;

  // The LSU has one result per cycle; the older slot keeps it.
  assign w_lsu_conflict = (au_mul_lsu1_wb == SEL_LSU) && (au_mul_lsu2_wb == SEL_LSU);

  assign w_illegal1 = !sel_legal(au_mul_lsu1_wb);
  assign w_illegal2 = !sel_legal(au_mul_lsu2_wb) || w_lsu_conflict;

  assign w_active1 = !w_illegal1 && (au_mul_lsu1_wb != SEL_NONE);
  assign w_active2 = !w_illegal2 && (au_mul_lsu2_wb != SEL_NONE);

  // --------------------------------------------------------------------------
  // Result muxes (zero for bubble or illegal)
  // --------------------------------------------------------------------------
  always_comb begin
    wb_data1 = '0;
    if (w_active1) begin
      case (au_mul_lsu1_wb)
        SEL_AU:  wb_data1 = au1_wb;
        SEL_MUL: wb_data1 = mul1_wb;
        SEL_LSU: wb_data1 = lsu_wb;
        default: wb_data1 = '0;
      endcase
    end
  end

  always_comb begin
    wb_data2 = '0;
    if (w_active2) begin
      case (au_mul_lsu2_wb)
        SEL_AU:  wb_data2 = au2_wb;
        SEL_MUL: wb_data2 = mul2_wb;
        SEL_LSU: wb_data2 = lsu_wb;
        default: wb_data2 = '0;
      endcase
    end
  end

  // x0 destinations never count as a commit, so forwarding never matches x0.
  assign wb_en1 = reg_write1_wb && w_active1 && (rd1_wb != REG_ZERO);
  assign wb_en2 = reg_write2_wb && w_active2 && (rd2_wb != REG_ZERO);

  // --------------------------------------------------------------------------
  // Error pulse and retire counter
  // --------------------------------------------------------------------------
  logic             r_sel_err;
  logic [CNT_W-1:0] r_retired_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel_err       <= 1'b0;
      r_retired_count <= '0;
    end else begin
      r_sel_err       <= w_illegal1 || w_illegal2;
      r_retired_count <= r_retired_count + CNT_W'(w_active1) + CNT_W'(w_active2);
    end
  end

  assign sel_err       = r_sel_err;
  assign retired_count = r_retired_count;

  // --------------------------------------------------------------------------
  // Register file
  // --------------------------------------------------------------------------
  logic [4:0]      w_raddr [4];
  logic [XLEN-1:0] w_rdata [4];

  assign w_raddr[0] = rs1a;
  assign w_raddr[1] = rs2a;
  assign w_raddr[2] = rs1b;
  assign w_raddr[3] = rs2b;

  regfile_4r2w #(
    .XLEN  (XLEN),
    .NREGS (NREGS),
    .AW    (5)
  ) u_regfile (
    .clk    (clk),
    .rst_n  (rst_n),
    .we1    (wb_en1),
    .waddr1 (rd1_wb),
    .wdata1 (wb_data1),
    .we2    (wb_en2),
    .waddr2 (rd2_wb),
    .wdata2 (wb_data2),
    .raddr  (w_raddr),
    .rdata  (w_rdata)
  );

  assign rd_data1a = w_rdata[0];
  assign rd_data2a = w_rdata[1];
  assign rd_data1b = w_rdata[2];
  assign rd_data2b = w_rdata[3];

endmodule : wb_regfile_stage
`default_nettype wire

// File: tb/tb_wb_regfile_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_regfile_stage
// Description : Self-checking bench for wb_regfile_stage. A table of directed
//               vectors with hand-computed results, then hand-written
//               sequences for mid-run reset and counter wrap (a second
//               instance with a 4-bit counter reaches the wrap quickly).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_regfile_stage;

  localparam logic [2:0] N = 3'b000;
  localparam logic [2:0] A = 3'b001;
  localparam logic [2:0] M = 3'b010;
  localparam logic [2:0] L = 3'b100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rw1, rw2;
  logic [4:0]  rd1, rd2;
  logic [2:0]  s1, s2;
  logic [31:0] au1, au2, mul1, mul2, lsu;
  logic [4:0]  rs1a, rs2a, rs1b, rs2b;

  logic [31:0] rd_data1a, rd_data2a, rd_data1b, rd_data2b;
  logic        wb_en1, wb_en2;
  logic [31:0] wb_data1, wb_data2;
  logic [63:0] retired_count;
  logic        sel_err;

  logic [31:0] n_rd_data1a, n_rd_data2a, n_rd_data1b, n_rd_data2b;
  logic        n_wb_en1, n_wb_en2;
  logic [31:0] n_wb_data1, n_wb_data2;
  logic [3:0]  n_retired_count;
  logic        n_sel_err;

  int checks   = 0;
  int failures = 0;
  logic [63:0] exp_cnt = 64'd0;

  always #5 clk = ~clk;

  wb_regfile_stage dut (
    .clk(clk), .rst_n(rst_n),
    .reg_write1_wb(rw1), .reg_write2_wb(rw2), .rd1_wb(rd1), .rd2_wb(rd2),
    .au_mul_lsu1_wb(s1), .au_mul_lsu2_wb(s2),
    .au1_wb(au1), .au2_wb(au2), .mul1_wb(mul1), .mul2_wb(mul2), .lsu_wb(lsu),
    .rs1a(rs1a), .rs2a(rs2a), .rs1b(rs1b), .rs2b(rs2b),
    .rd_data1a(rd_data1a), .rd_data2a(rd_data2a),
    .rd_data1b(rd_data1b), .rd_data2b(rd_data2b),
    .wb_en1(wb_en1), .wb_en2(wb_en2), .wb_data1(wb_data1), .wb_data2(wb_data2),
    .retired_count(retired_count), .sel_err(sel_err)
  );

  wb_regfile_stage #(.CNT_W(4)) dut_w4 (
    .clk(clk), .rst_n(rst_n),
    .reg_write1_wb(rw1), .reg_write2_wb(rw2), .rd1_wb(rd1), .rd2_wb(rd2),
    .au_mul_lsu1_wb(s1), .au_mul_lsu2_wb(s2),
    .au1_wb(au1), .au2_wb(au2), .mul1_wb(mul1), .mul2_wb(mul2), .lsu_wb(lsu),
    .rs1a(rs1a), .rs2a(rs2a), .rs1b(rs1b), .rs2b(rs2b),
    .rd_data1a(n_rd_data1a), .rd_data2a(n_rd_data2a),
    .rd_data1b(n_rd_data1b), .rd_data2b(n_rd_data2b),
    .wb_en1(n_wb_en1), .wb_en2(n_wb_en2), .wb_data1(n_wb_data1), .wb_data2(n_wb_data2),
    .retired_count(n_retired_count), .sel_err(n_sel_err)
  );

  typedef struct {
    logic             rw1, rw2;
    logic [4:0]       rd1, rd2;
    logic [2:0]       s1, s2;
    logic [31:0]      au1, au2, mul1, mul2, lsu;
    logic [0:3][4:0]  ra;    // rs1a, rs2a, rs1b, rs2b
    logic             en1, en2;
    logic [31:0]      d1, d2;
    logic [0:3][31:0] rdx;   // same-cycle read data, same order as ra
    logic             err;   // sel_err after the edge
    logic [63:0]      cnt;   // retired_count after the edge
  } vec_t;

  localparam int NV = 13;
  vec_t vt [NV];

  function automatic vec_t mk(
    input logic w1, input logic [4:0] d1a, input logic [2:0] x1,
    input logic [31:0] a1, input logic [31:0] m1,
    input logic w2, input logic [4:0] d2a, input logic [2:0] x2,
    input logic [31:0] a2, input logic [31:0] m2, input logic [31:0] l,
    input logic [0:3][4:0] ra, input logic e1, input logic e2,
    input logic [31:0] o1, input logic [31:0] o2, input logic [0:3][31:0] rdx,
    input logic err, input logic [63:0] cnt);
    vec_t v;
    v.rw1 = w1; v.rd1 = d1a; v.s1 = x1; v.au1 = a1; v.mul1 = m1;
    v.rw2 = w2; v.rd2 = d2a; v.s2 = x2; v.au2 = a2; v.mul2 = m2; v.lsu = l;
    v.ra = ra; v.en1 = e1; v.en2 = e2; v.d1 = o1; v.d2 = o2; v.rdx = rdx;
    v.err = err; v.cnt = cnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rw1 = v.rw1; rd1 = v.rd1; s1 = v.s1; au1 = v.au1; mul1 = v.mul1;
    rw2 = v.rw2; rd2 = v.rd2; s2 = v.s2; au2 = v.au2; mul2 = v.mul2;
    lsu = v.lsu;
    rs1a = v.ra[0]; rs2a = v.ra[1]; rs1b = v.ra[2]; rs2b = v.ra[3];
  endtask

  task automatic bubble(input logic [4:0] a0, input logic [4:0] a1,
                        input logic [4:0] a2, input logic [4:0] a3);
    rw1 = 0; rd1 = 0; s1 = N; au1 = 0; mul1 = 0;
    rw2 = 0; rd2 = 0; s2 = N; au2 = 0; mul2 = 0; lsu = 0;
    rs1a = a0; rs2a = a1; rs1b = a2; rs2b = a3;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    //            rw1 rd1 s1    au1          mul1       rw2 rd2 s2     au2   mul2   lsu    reads               en1 en2 d1            d2      read data                                 err cnt
    vt[0]  = mk(0, 0, N,    0,            0,         0, 0, N,     0,    0,     0,     {5'd5,5'd5,5'd5,5'd5}, 0, 0, 0,            0,      {32'h0,32'h0,32'h0,32'h0},                 0, 0);
    vt[1]  = mk(1, 3, A,    32'h11,       32'h77,    1, 4, M,     32'h99, 32'h22, 32'h66, {5'd3,5'd4,5'd0,5'd5}, 1, 1, 32'h11,     32'h22, {32'h11,32'h22,32'h0,32'h0},               0, 2);
    vt[2]  = mk(0, 0, N,    0,            0,         0, 0, N,     0,    0,     0,     {5'd3,5'd4,5'd3,5'd4}, 0, 0, 0,            0,      {32'h11,32'h22,32'h11,32'h22},             0, 2);
    vt[3]  = mk(1, 7, A,    32'hA,        0,         1, 7, A,     32'hB, 0,     0,     {5'd7,5'd7,5'd7,5'd3}, 1, 1, 32'hA,      32'hB,  {32'hB,32'hB,32'hB,32'h11},                0, 4);
    vt[4]  = mk(0, 0, N,    0,            0,         0, 0, N,     0,    0,     0,     {5'd7,5'd0,5'd7,5'd4}, 0, 0, 0,            0,      {32'hB,32'h0,32'hB,32'h22},                0, 4);
    vt[5]  = mk(1, 0, A,    32'hFFFFFFFF, 0,         0, 0, N,     0,    0,     0,     {5'd0,5'd0,5'd0,5'd0}, 0, 0, 32'hFFFFFFFF, 0,    {32'h0,32'h0,32'h0,32'h0},                 0, 5);
    vt[6]  = mk(1, 8, L,    32'h1,        32'h2,     1, 9, L,     32'h3, 32'h4, 32'h55, {5'd8,5'd9,5'd8,5'd9}, 1, 0, 32'h55,     0,      {32'h55,32'h0,32'h55,32'h0},               1, 6);
    vt[7]  = mk(0, 0, N,    0,            0,         0, 0, N,     0,    0,     0,     {5'd8,5'd9,5'd0,5'd7}, 0, 0, 0,            0,      {32'h55,32'h0,32'h0,32'hB},                0, 6);
    vt[8]  = mk(1, 10, 3'b011, 32'h1,     32'h2,     1, 11, M,    0,    32'h33, 0,     {5'd10,5'd11,5'd11,5'd8}, 0, 1, 0,          32'h33, {32'h0,32'h33,32'h33,32'h55},              1, 7);
    vt[9]  = mk(0, 12, A,   32'h44,       0,         0, 0, L,     0,    0,     32'h66, {5'd12,5'd11,5'd0,5'd3}, 0, 0, 32'h44,   32'h66, {32'h0,32'h33,32'h0,32'h11},               0, 9);
    vt[10] = mk(1, 13, L,   0,            0,         1, 14, 3'b110, 32'h5, 32'h6, 32'h77, {5'd13,5'd14,5'd13,5'd14}, 1, 0, 32'h77, 0,     {32'h77,32'h0,32'h77,32'h0},               1, 10);
    vt[11] = mk(0, 0, N,    0,            0,         0, 0, N,     0,    0,     0,     {5'd10,5'd12,5'd13,5'd14}, 0, 0, 0,        0,      {32'h0,32'h0,32'h77,32'h0},                0, 10);
    vt[12] = mk(1, 3, A,    32'h123,      0,         0, 0, N,     0,    0,     0,     {5'd3,5'd4,5'd3,5'd0}, 1, 0, 32'h123,    0,      {32'h123,32'h22,32'h123,32'h0},            0, 11);

    // Reset state
    bubble(5, 5, 5, 5);
    #12;
    chk("reset_cnt", retired_count, 64'd0);
    chk("reset_err", {63'd0, sel_err}, 64'd0);
    chk("reset_rd1a_x5", {32'd0, rd_data1a}, 64'd0);
    chk("reset_rd2b_x5", {32'd0, rd_data2b}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven vectors
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(vt[i]);
      #1;
      chk($sformatf("v%0d_en1", i), {63'd0, wb_en1}, {63'd0, vt[i].en1});
      chk($sformatf("v%0d_en2", i), {63'd0, wb_en2}, {63'd0, vt[i].en2});
      chk($sformatf("v%0d_d1", i), {32'd0, wb_data1}, {32'd0, vt[i].d1});
      chk($sformatf("v%0d_d2", i), {32'd0, wb_data2}, {32'd0, vt[i].d2});
      chk($sformatf("v%0d_rd1a", i), {32'd0, rd_data1a}, {32'd0, vt[i].rdx[0]});
      chk($sformatf("v%0d_rd2a", i), {32'd0, rd_data2a}, {32'd0, vt[i].rdx[1]});
      chk($sformatf("v%0d_rd1b", i), {32'd0, rd_data1b}, {32'd0, vt[i].rdx[2]});
      chk($sformatf("v%0d_rd2b", i), {32'd0, rd_data2b}, {32'd0, vt[i].rdx[3]});
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_err", i), {63'd0, sel_err}, {63'd0, vt[i].err});
      chk($sformatf("v%0d_cnt", i), retired_count, vt[i].cnt);
      chk($sformatf("v%0d_cnt4", i), {60'd0, n_retired_count}, {60'd0, vt[i].cnt[3:0]});
    end
    exp_cnt = 64'd11;

    // Mid-run reset: commit x5, then reset with a write to x6 in flight
    @(negedge clk);
    bubble(0, 0, 0, 0);
    rw1 = 1; rd1 = 5; s1 = A; au1 = 32'hDEADBEEF;
    @(posedge clk);
    @(negedge clk);
    bubble(5, 0, 0, 0);
    #1;
    chk("pre_reset_x5", {32'd0, rd_data1a}, 64'hDEADBEEF);
    @(negedge clk);
    bubble(5, 6, 5, 0);
    rw1 = 1; rd1 = 6; s1 = A; au1 = 32'h1;
    rst_n = 1'b0;
    #1;
    chk("in_reset_x5", {32'd0, rd_data1a}, 64'd0);
    chk("in_reset_cnt", retired_count, 64'd0);
    @(posedge clk);
    #1;
    chk("in_reset_x5_edge", {32'd0, rd_data1b}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bubble(5, 6, 0, 0);
    #1;
    chk("post_reset_x5", {32'd0, rd_data1a}, 64'd0);
    chk("post_reset_x6", {32'd0, rd_data2a}, 64'd0);
    chk("post_reset_cnt", retired_count, 64'd0);
    exp_cnt = 64'd0;

    // Counter wrap on the 4-bit instance: 15 single retirements, then a pair
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      bubble(0, 0, 0, 0);
      s1 = A; au1 = 32'(k);
      @(posedge clk);
      exp_cnt = exp_cnt + 64'd1;
    end
    #1;
    chk("wrap_pre_cnt4", {60'd0, n_retired_count}, 64'd15);
    chk("wrap_pre_cnt", retired_count, exp_cnt);
    @(negedge clk);
    bubble(0, 0, 0, 0);
    s1 = A; s2 = M;
    @(posedge clk);
    exp_cnt = exp_cnt + 64'd2;
    #1;
    chk("wrap_cnt4", {60'd0, n_retired_count}, 64'd1);
    chk("wrap_cnt", retired_count, exp_cnt);

    @(negedge clk);
    bubble(0, 0, 0, 0);
    @(posedge clk);
    #1;
    chk("final_cnt", retired_count, exp_cnt);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_wb_regfile_stage
`default_nettype wire
